carrd_vmem_responder: RTL and testbench
=======================================

# carrd_vmem_responder

Memory-side responder for the vector coprocessor's four-lane data-memory interface. It accepts one vector load or store request, carrying four per-lane byte addresses and store words. It serves the request from four interleaved word banks, serializing lanes that collide on a bank, and returns four load words with a one-cycle response strobe. It sits between the coprocessor's load/store unit and the on-chip data memory, in place of a direct memory hookup.

## Interface
- `BANK_WORDS`, default 256: depth of each of the 4 banks in 32-bit words. Total capacity is 4*BANK_WORDS words.
- `clk` in 1: single clock. All state updates on the rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present. The initiator holds all request inputs stable until accepted.
- `req_ready` out 1: high only in IDLE.
- `is_vstype` in 1: 1 means store request, 0 means load request. Sampled at accept.
- `lane_size0..3` in 2 each: lane access size. 0 is lane inactive, 1 byte, 2 halfword, 3 word.
- `data_addr0..3` in `DATAMEM_BITS` each: byte address per lane.
- `v_store_data_0..3` in `DATAMEM_WIDTH` (32) each: store data, right-aligned.
- `v_load_data_0..3` out `DATAMEM_WIDTH` each: load data, right-aligned and zero-extended. Held stable until the next accept.
- `resp_valid` out 1: one-cycle pulse when the request completes.
- `resp_err` out 1: valid with `resp_valid`. Set if any active lane was misaligned.

## Operation
**Address decode**
- Bank is `addr[3:2]`; word index is `addr[DATAMEM_BITS-1:4]`, truncated to log2(BANK_WORDS) bits.
- A lane is misaligned if it is a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
- A misaligned lane is dropped: no memory access, load result 0, and `resp_err` is set.

**Accept**
- A request is accepted when `req_valid && req_ready`.
- On accept, latch the addresses, sizes, store data and `is_vstype`.
- Build a pending mask of the active, aligned lanes.
- Clear all load-result registers.

**FSM: IDLE → SERVE → WAIT → RESP → IDLE**
- SERVE: for each bank, grant the lowest-indexed pending lane that targets it. Clear the granted lanes from the pending mask. Stay in SERVE while the mask after this cycle's grants is nonzero, otherwise go to WAIT. An empty mask at accept still passes through one SERVE cycle.
- WAIT: no grants. Capture the final read data.
- RESP: `resp_valid`=1 for exactly one cycle, then return to IDLE.

**Stores**
- A granted store lane writes at the end of its grant cycle, using byte enables.
  - Byte: data[7:0] goes to byte `addr[1:0]`.
  - Half: data[15:0] goes to half `addr[1]`.
  - Word: full word.
- Two lanes hitting the same word are served lower lane first, so the higher lane's bytes persist.

**Loads**
- Reads are synchronous. Data read at the grant edge is extracted by size and offset, zero-extended, and captured into that lane's result register at the following edge.
- Lane ID, size and offset are delayed one cycle alongside the read.
- Inactive or misaligned lanes read back 0.

**Reset and stalls**
- Reset, including mid-request, forces IDLE and the request is abandoned.
- Reset values: `req_ready`=1 after reset, `resp_valid`=0, `resp_err`=0, `v_load_data_*`=0.
- Memory contents are not reset.
- `req_valid` while `req_ready`=0 is ignored.

## Timing
- Accept edge is E0. With no bank conflicts: SERVE during cycle 1, WAIT during cycle 2, RESP (`resp_valid`) during cycle 3.
- Latency is 3 + (max lanes sharing one bank − 1) cycles from the accept edge. Range is 3 to 6.
- `req_ready` falls in the cycle after accept and rises in the cycle after RESP. The next accept is possible 4 cycles after the previous one at best.
- Store effects are visible to any subsequent request.

## Structure
- Additions to `v_pkg`:
  - `NUM_VLANES`=4 and `NUM_VBANKS`=4.
  - Enum `vmem_size_e` (OFF, BYTE, HALF, WORD).
  - Enum `vmem_state_e` (IDLE, SERVE, WAIT, RESP).
- One sub-module, `carrd_vmem_bank`: BANK_WORDS×32, synchronous read, 4-bit byte write enable. It is instantiated 4 times.
- The grant arbiter and the load extraction live in the top module.

## Test plan
- Word store to addresses 0x00/0x04/0x08/0x0C with data 0x11111111..0x44444444, then a word load of the same addresses → loads return 0x11111111..0x44444444, `resp_valid` 3 cycles after each accept, `resp_err`=0.
- Word load with all lanes at 0x00/0x10/0x20/0x30 (all bank 0) after storing 0xA0..0xA3 there → data 0xA0..0xA3 in lane order, `resp_valid` 6 cycles after accept.
- Byte stores to 0x41 (data 0xAB, lane 0) and 0x41 (data 0xCD, lane 2), then a word load of 0x40 → byte 1 = 0xCD, and the latency shows serialization (4 cycles).
- Halfword load at 0x42 after storing word 0xDEADBEEF at 0x40 → 0x0000DEAD. A halfword at 0x43 → that lane returns 0 and `resp_err`=1.
- All lanes `lane_size`=0 → `resp_valid` at 3 cycles, all loads 0, no memory change.
- Assert `nrst`=0 during SERVE of a 4-way-conflict store → IDLE, `req_ready`=1, no `resp_valid`. A follow-up load runs normally.

Source files
------------

// File: rtl/v_pkg.sv
// Shared types and helpers for the vector data-memory responder.
// Lane sizes, FSM states, alignment check and load-lane extraction.
package v_pkg;

    localparam int DATAMEM_BITS  = 12;
    localparam int DATAMEM_WIDTH = 32;
    localparam int NUM_VLANES    = 4;
    localparam int NUM_VBANKS    = 4;

    typedef enum logic [1:0] {
        VSZ_OFF  = 2'd0,
        VSZ_BYTE = 2'd1,
        VSZ_HALF = 2'd2,
        VSZ_WORD = 2'd3
    } vmem_size_e;

    typedef enum logic [1:0] {
        VST_IDLE  = 2'd0,
        VST_SERVE = 2'd1,
        VST_WAIT  = 2'd2,
        VST_RESP  = 2'd3
    } vmem_state_e;

    function automatic logic vmem_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == VSZ_HALF) && off[0]) || ((size == VSZ_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [DATAMEM_WIDTH-1:0] vmem_extract(
        input logic [1:0]               size,
        input logic [1:0]               off,
        input logic [DATAMEM_WIDTH-1:0] word
    );
        logic [DATAMEM_WIDTH-1:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            VSZ_BYTE: return {24'h0, sh[7:0]};
            VSZ_HALF: return {16'h0, sh[15:0]};
            VSZ_WORD: return word;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/carrd_vmem_bank.sv
// One interleaved word bank: synchronous read, byte-enabled write, no reset.
// Read data appears one edge after the address; never stalls.
module carrd_vmem_bank
    import v_pkg::*;
#(
    parameter int BANK_WORDS = 256,
    parameter int IDX_W      = $clog2(BANK_WORDS)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [IDX_W-1:0]         idx,
    input  logic [DATAMEM_WIDTH-1:0] wdata,
    output logic [DATAMEM_WIDTH-1:0] rdata
);

    logic [DATAMEM_WIDTH-1:0] mem [BANK_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/carrd_vmem_responder.sv
// Four-lane vector load/store responder over four word banks; lanes colliding on a bank are serialized.
// Latency 3..6 cycles from accept; req_ready only in IDLE, so one request is in flight at a time.
module carrd_vmem_responder
    import v_pkg::*;
#(
    parameter int BANK_WORDS = 256
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     is_vstype,
    input  logic [1:0]               lane_size0,
    input  logic [1:0]               lane_size1,
    input  logic [1:0]               lane_size2,
    input  logic [1:0]               lane_size3,
    input  logic [DATAMEM_BITS-1:0]  data_addr0,
    input  logic [DATAMEM_BITS-1:0]  data_addr1,
    input  logic [DATAMEM_BITS-1:0]  data_addr2,
    input  logic [DATAMEM_BITS-1:0]  data_addr3,
    input  logic [DATAMEM_WIDTH-1:0] v_store_data_0,
    input  logic [DATAMEM_WIDTH-1:0] v_store_data_1,
    input  logic [DATAMEM_WIDTH-1:0] v_store_data_2,
    input  logic [DATAMEM_WIDTH-1:0] v_store_data_3,
    output logic [DATAMEM_WIDTH-1:0] v_load_data_0,
    output logic [DATAMEM_WIDTH-1:0] v_load_data_1,
    output logic [DATAMEM_WIDTH-1:0] v_load_data_2,
    output logic [DATAMEM_WIDTH-1:0] v_load_data_3,
    output logic                     resp_valid,
    output logic                     resp_err
);

    localparam int IDX_W = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

    localparam logic [1:0] ST_IDLE  = VST_IDLE;
    localparam logic [1:0] ST_SERVE = VST_SERVE;
    localparam logic [1:0] ST_WAIT  = VST_WAIT;
    localparam logic [1:0] ST_RESP  = VST_RESP;

    logic [DATAMEM_BITS-1:0]  in_addr [NUM_VLANES];
    logic [1:0]               in_size [NUM_VLANES];
    logic [DATAMEM_WIDTH-1:0] in_sdat [NUM_VLANES];

    assign in_addr[0] = data_addr0;
    assign in_addr[1] = data_addr1;
    assign in_addr[2] = data_addr2;
    assign in_addr[3] = data_addr3;
    assign in_size[0] = lane_size0;
    assign in_size[1] = lane_size1;
    assign in_size[2] = lane_size2;
    assign in_size[3] = lane_size3;
    assign in_sdat[0] = v_store_data_0;
    assign in_sdat[1] = v_store_data_1;
    assign in_sdat[2] = v_store_data_2;
    assign in_sdat[3] = v_store_data_3;

    logic [1:0]               state_q, state_d;
    logic                     is_st_q, is_st_d;
    logic                     err_q, err_d;
    logic [NUM_VLANES-1:0]    pend_q, pend_d;
    logic [DATAMEM_BITS-1:0]  addr_q [NUM_VLANES];
    logic [DATAMEM_BITS-1:0]  addr_d [NUM_VLANES];
    logic [1:0]               size_q [NUM_VLANES];
    logic [1:0]               size_d [NUM_VLANES];
    logic [DATAMEM_WIDTH-1:0] sdat_q [NUM_VLANES];
    logic [DATAMEM_WIDTH-1:0] sdat_d [NUM_VLANES];
    logic [DATAMEM_WIDTH-1:0] ld_q   [NUM_VLANES];
    logic [DATAMEM_WIDTH-1:0] ld_d   [NUM_VLANES];

    // Per-bank read bookkeeping, delayed one cycle to line up with bank read data.
    logic [NUM_VBANKS-1:0]    rd_vld_q, rd_vld_d;
    logic [1:0]               rd_lane_q [NUM_VBANKS];
    logic [1:0]               rd_lane_d [NUM_VBANKS];
    logic [1:0]               rd_size_q [NUM_VBANKS];
    logic [1:0]               rd_size_d [NUM_VBANKS];
    logic [1:0]               rd_off_q  [NUM_VBANKS];
    logic [1:0]               rd_off_d  [NUM_VBANKS];

    logic [NUM_VBANKS-1:0]    bk_gnt;
    logic [1:0]               bk_lane [NUM_VBANKS];
    logic [NUM_VLANES-1:0]    gnt_mask;
    logic [NUM_VBANKS-1:0]    bk_we;
    logic [3:0]               bk_be   [NUM_VBANKS];
    logic [IDX_W-1:0]         bk_idx  [NUM_VBANKS];
    logic [DATAMEM_WIDTH-1:0] bk_wdat [NUM_VBANKS];
    logic [DATAMEM_WIDTH-1:0] bk_rdat [NUM_VBANKS];

    // Each bank takes its lowest-indexed pending lane; the descending scan leaves that one last.
    always_comb begin
        gnt_mask = '0;
        for (int b = 0; b < NUM_VBANKS; b++) begin
            bk_gnt[b]  = 1'b0;
            bk_lane[b] = 2'd0;
        end
        if (state_q == ST_SERVE) begin
            for (int b = 0; b < NUM_VBANKS; b++) begin
                for (int l = NUM_VLANES - 1; l >= 0; l--) begin
                    if (pend_q[l] && (addr_q[l][3:2] == 2'(b))) begin
                        bk_gnt[b]  = 1'b1;
                        bk_lane[b] = 2'(l);
                    end
                end
            end
        end
        for (int b = 0; b < NUM_VBANKS; b++) begin
            if (bk_gnt[b]) begin
                gnt_mask[bk_lane[b]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_VBANKS; b++) begin
            bk_we[b]     = bk_gnt[b] && is_st_q;
            bk_idx[b]    = IDX_W'(addr_q[bk_lane[b]][DATAMEM_BITS-1:4]);
            rd_vld_d[b]  = bk_gnt[b] && !is_st_q;
            rd_lane_d[b] = bk_lane[b];
            rd_size_d[b] = size_q[bk_lane[b]];
            rd_off_d[b]  = addr_q[bk_lane[b]][1:0];
            case (size_q[bk_lane[b]])
                VSZ_BYTE: begin
                    bk_be[b]   = 4'b0001 << addr_q[bk_lane[b]][1:0];
                    bk_wdat[b] = {4{sdat_q[bk_lane[b]][7:0]}};
                end
                VSZ_HALF: begin
                    bk_be[b]   = addr_q[bk_lane[b]][1] ? 4'b1100 : 4'b0011;
                    bk_wdat[b] = {2{sdat_q[bk_lane[b]][15:0]}};
                end
                default: begin
                    bk_be[b]   = 4'b1111;
                    bk_wdat[b] = sdat_q[bk_lane[b]];
                end
            endcase
        end
    end

    for (genvar b = 0; b < NUM_VBANKS; b++) begin : g_bank
        carrd_vmem_bank #(
            .BANK_WORDS (BANK_WORDS),
            .IDX_W      (IDX_W)
        ) u_bank (
            .clk   (clk),
            .we    (bk_we[b]),
            .be    (bk_be[b]),
            .idx   (bk_idx[b]),
            .wdata (bk_wdat[b]),
            .rdata (bk_rdat[b])
        );
    end

    always_comb begin
        state_d = state_q;
        is_st_d = is_st_q;
        err_d   = err_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sdat_d  = sdat_q;
        ld_d    = ld_q;

        for (int b = 0; b < NUM_VBANKS; b++) begin
            if (rd_vld_q[b]) begin
                ld_d[rd_lane_q[b]] = vmem_extract(rd_size_q[b], rd_off_q[b], bk_rdat[b]);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    is_st_d = is_vstype;
                    err_d   = 1'b0;
                    for (int l = 0; l < NUM_VLANES; l++) begin
                        addr_d[l] = in_addr[l];
                        size_d[l] = in_size[l];
                        sdat_d[l] = in_sdat[l];
                        ld_d[l]   = '0;
                        pend_d[l] = (in_size[l] != VSZ_OFF) && !vmem_misaligned(in_size[l], in_addr[l][1:0]);
                        if ((in_size[l] != VSZ_OFF) && vmem_misaligned(in_size[l], in_addr[l][1:0])) begin
                            err_d = 1'b1;
                        end
                    end
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                pend_d  = pend_q & ~gnt_mask;
                state_d = (pend_d != '0) ? ST_SERVE : ST_WAIT;
            end
            ST_WAIT: state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            is_st_q  <= 1'b0;
            err_q    <= 1'b0;
            pend_q   <= '0;
            rd_vld_q <= '0;
            for (int l = 0; l < NUM_VLANES; l++) begin
                addr_q[l] <= '0;
                size_q[l] <= '0;
                sdat_q[l] <= '0;
                ld_q[l]   <= '0;
            end
            for (int b = 0; b < NUM_VBANKS; b++) begin
                rd_lane_q[b] <= '0;
                rd_size_q[b] <= '0;
                rd_off_q[b]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            is_st_q  <= is_st_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
            rd_vld_q <= rd_vld_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            sdat_q   <= sdat_d;
            ld_q     <= ld_d;
            rd_lane_q <= rd_lane_d;
            rd_size_q <= rd_size_d;
            rd_off_q  <= rd_off_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = (state_q == ST_RESP);
    assign resp_err      = resp_valid && err_q;
    assign v_load_data_0 = ld_q[0];
    assign v_load_data_1 = ld_q[1];
    assign v_load_data_2 = ld_q[2];
    assign v_load_data_3 = ld_q[3];

endmodule

// File: tb/tb_carrd_vmem_responder.sv
// Directed bench for carrd_vmem_responder: stores, loads, bank conflicts, alignment and reset.
module tb_carrd_vmem_responder;
    import v_pkg::*;

    logic                     clk = 1'b0;
    logic                     nrst = 1'b1;
    logic                     req_valid = 1'b0;
    logic                     req_ready;
    logic                     is_vstype = 1'b0;
    logic [1:0]               lane_size0 = '0, lane_size1 = '0, lane_size2 = '0, lane_size3 = '0;
    logic [DATAMEM_BITS-1:0]  data_addr0 = '0, data_addr1 = '0, data_addr2 = '0, data_addr3 = '0;
    logic [DATAMEM_WIDTH-1:0] v_store_data_0 = '0, v_store_data_1 = '0, v_store_data_2 = '0, v_store_data_3 = '0;
    logic [DATAMEM_WIDTH-1:0] v_load_data_0, v_load_data_1, v_load_data_2, v_load_data_3;
    logic                     resp_valid;
    logic                     resp_err;

    int total = 0;
    int bad   = 0;

    carrd_vmem_responder #(.BANK_WORDS(256)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready), .is_vstype(is_vstype),
        .lane_size0(lane_size0), .lane_size1(lane_size1), .lane_size2(lane_size2), .lane_size3(lane_size3),
        .data_addr0(data_addr0), .data_addr1(data_addr1), .data_addr2(data_addr2), .data_addr3(data_addr3),
        .v_store_data_0(v_store_data_0), .v_store_data_1(v_store_data_1),
        .v_store_data_2(v_store_data_2), .v_store_data_3(v_store_data_3),
        .v_load_data_0(v_load_data_0), .v_load_data_1(v_load_data_1),
        .v_load_data_2(v_load_data_2), .v_load_data_3(v_load_data_3),
        .resp_valid(resp_valid), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Drives one request (lane 0 in the low bits), then counts cycles to resp_valid; lat=-1 on timeout.
    task automatic do_req(input logic st, input logic [7:0] sz, input logic [47:0] ad,
                          input logic [127:0] wd, output int lat, output logic err, output logic rdy1);
        @(negedge clk);
        is_vstype = st;
        lane_size0 = sz[1:0];  lane_size1 = sz[3:2];  lane_size2 = sz[5:4];  lane_size3 = sz[7:6];
        data_addr0 = ad[11:0]; data_addr1 = ad[23:12]; data_addr2 = ad[35:24]; data_addr3 = ad[47:36];
        v_store_data_0 = wd[31:0];  v_store_data_1 = wd[63:32];
        v_store_data_2 = wd[95:64]; v_store_data_3 = wd[127:96];
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; err = 1'b0; rdy1 = 1'bx;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) rdy1 = req_ready;
            if (resp_valid) begin
                lat = c;
                err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b1;
        #1 nrst = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
        total++;
        if ({v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0} !== 128'h0) begin
            bad++; $display("FAIL reset_load_data got=%h want=0", {v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0});
        end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_word_store_load();
        int lat; logic err; logic rdy1;
        do_req(1'b1, 8'hFF, {12'h00C, 12'h008, 12'h004, 12'h000},
               {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, lat, err, rdy1);
        total++; if (lat != 3) begin bad++; $display("FAIL word_store_lat got=%0d want=3", lat); end
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL word_store_busy_ready got=%b want=0", rdy1); end
        do_req(1'b0, 8'hFF, {12'h00C, 12'h008, 12'h004, 12'h000}, 128'h0, lat, err, rdy1);
        total++; if (lat != 3) begin bad++; $display("FAIL word_load_lat got=%0d want=3", lat); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL word_load_err got=%b want=0", err); end
        total++;
        if ({v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0} !== {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}) begin
            bad++; $display("FAIL word_load_data got=%h want=44444444333333332222222211111111",
                            {v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0});
        end
    endtask

    task automatic test_bank_conflict();
        int lat; logic err; logic rdy1;
        do_req(1'b1, 8'hFF, {12'h030, 12'h020, 12'h010, 12'h000},
               {32'hA3, 32'hA2, 32'hA1, 32'hA0}, lat, err, rdy1);
        total++; if (lat != 6) begin bad++; $display("FAIL conflict_store_lat got=%0d want=6", lat); end
        do_req(1'b0, 8'hFF, {12'h030, 12'h020, 12'h010, 12'h000}, 128'h0, lat, err, rdy1);
        total++; if (lat != 6) begin bad++; $display("FAIL conflict_load_lat got=%0d want=6", lat); end
        total++;
        if ({v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0} !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
            bad++; $display("FAIL conflict_load_data got=%h want=000000a3000000a2000000a1000000a0",
                            {v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0});
        end
    endtask

    task automatic test_byte_collide();
        int lat; logic err; logic rdy1;
        do_req(1'b1, 8'h03, {12'h0, 12'h0, 12'h0, 12'h040}, 128'h0, lat, err, rdy1);
        do_req(1'b1, {2'd0, 2'd1, 2'd0, 2'd1}, {12'h0, 12'h041, 12'h0, 12'h041},
               {32'h0, 32'hCD, 32'h0, 32'hAB}, lat, err, rdy1);
        total++; if (lat != 4) begin bad++; $display("FAIL byte_store_lat got=%0d want=4", lat); end
        do_req(1'b0, 8'h03, {12'h0, 12'h0, 12'h0, 12'h040}, 128'h0, lat, err, rdy1);
        total++; if (v_load_data_0 !== 32'h0000CD00) begin bad++; $display("FAIL byte_collide_data got=%h want=0000cd00", v_load_data_0); end
        total++; if (lat != 3) begin bad++; $display("FAIL byte_reload_lat got=%0d want=3", lat); end
    endtask

    task automatic test_half_misalign();
        int lat; logic err; logic rdy1;
        do_req(1'b1, 8'h03, {12'h0, 12'h0, 12'h0, 12'h040}, {96'h0, 32'hDEADBEEF}, lat, err, rdy1);
        do_req(1'b0, {2'd1, 2'd1, 2'd2, 2'd2}, {12'h040, 12'h041, 12'h043, 12'h042}, 128'h0, lat, err, rdy1);
        total++; if (v_load_data_0 !== 32'h0000DEAD) begin bad++; $display("FAIL half_load_data got=%h want=0000dead", v_load_data_0); end
        total++; if (v_load_data_1 !== 32'h0) begin bad++; $display("FAIL half_misaligned_data got=%h want=00000000", v_load_data_1); end
        total++; if (v_load_data_2 !== 32'h000000BE) begin bad++; $display("FAIL byte1_load_data got=%h want=000000be", v_load_data_2); end
        total++; if (v_load_data_3 !== 32'h000000EF) begin bad++; $display("FAIL byte0_load_data got=%h want=000000ef", v_load_data_3); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL half_misaligned_err got=%b want=1", err); end
        total++; if (lat != 5) begin bad++; $display("FAIL half_mix_lat got=%0d want=5", lat); end
    endtask

    task automatic test_all_off();
        int lat; logic err; logic rdy1;
        do_req(1'b0, 8'h00, {12'h040, 12'h040, 12'h040, 12'h040}, 128'h0, lat, err, rdy1);
        total++; if (lat != 3) begin bad++; $display("FAIL off_load_lat got=%0d want=3", lat); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL off_load_err got=%b want=0", err); end
        total++;
        if ({v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0} !== 128'h0) begin
            bad++; $display("FAIL off_load_data got=%h want=0", {v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0});
        end
        do_req(1'b1, 8'h00, {12'h030, 12'h020, 12'h010, 12'h000}, {4{32'hFFFFFFFF}}, lat, err, rdy1);
        total++; if (lat != 3) begin bad++; $display("FAIL off_store_lat got=%0d want=3", lat); end
    endtask

    task automatic test_reset_mid();
        int lat; logic err; logic rdy1; logic saw;
        @(negedge clk);
        is_vstype = 1'b1;
        lane_size0 = 2'd3; lane_size1 = 2'd3; lane_size2 = 2'd3; lane_size3 = 2'd3;
        data_addr0 = 12'h000; data_addr1 = 12'h010; data_addr2 = 12'h020; data_addr3 = 12'h030;
        v_store_data_0 = 32'hBAD0; v_store_data_1 = 32'hBAD1; v_store_data_2 = 32'hBAD2; v_store_data_3 = 32'hBAD3;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_busy_ready got=%b want=0", req_ready); end
        nrst = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_ready got=%b want=1", req_ready); end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) saw = 1'b1;
        end
        total++; if (saw !== 1'b0) begin bad++; $display("FAIL mid_reset_resp got=%b want=0", saw); end
        do_req(1'b0, 8'hFF, {12'h030, 12'h020, 12'h010, 12'h000}, 128'h0, lat, err, rdy1);
        total++; if (lat != 6) begin bad++; $display("FAIL post_reset_lat got=%0d want=6", lat); end
        total++;
        if ({v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0} !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
            bad++; $display("FAIL post_reset_data got=%h want=000000a3000000a2000000a1000000a0",
                            {v_load_data_3, v_load_data_2, v_load_data_1, v_load_data_0});
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_bank_conflict();
        test_byte_collide();
        test_half_misalign();
        test_all_off();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
